mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
Two-master arbiter that shares the single memory port (mem_read/mem_write/mem_ack request-acknowledge bus) between the CPU (master 0) and a second bus master such as video fetch or DMA (master 1). It sits between the masters and the memory controller, latches the winning request and drives the memory port until mem_ack. It then returns read data and a one-cycle acknowledge to the winning master. Arbitration is round-robin.

Parameters:
ADDR_W, 32, address width of masters and memory port
DATA_W, 32, data width of masters and memory port
TIMEOUT, 255, maximum ACCESS cycles without mem_ack; used only with MEM_ARB_TIMEOUT_EN

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
m0_read  input  1  master 0 read request, held until m0_ack
m0_write  input  1  master 0 write request, held until m0_ack
m0_addr  input  ADDR_W  master 0 address
m0_wdata  input  DATA_W  master 0 write data
m0_ack  output  1  one-cycle completion pulse to master 0
m0_rdata  output  DATA_W  read data, valid while m0_ack=1
m0_err  output  1  timeout flag, coincident with m0_ack
m1_read, m1_write, m1_addr, m1_wdata, m1_ack, m1_rdata, m1_err: same as master 0, for master 1
mem_read  output  1  read strobe to memory, held until mem_ack
mem_write  output  1  write strobe to memory, held until mem_ack
mem_addr  output  ADDR_W  latched address
mem_write_data  output  DATA_W  latched write data
mem_ack  input  1  memory completion; qualifies mem_read_data
mem_read_data  input  DATA_W  memory read data
owner  output  1  master currently or last granted
busy  output  1  high in ACCESS and DONE

Behaviour:
- Reset (reset=0, async): state=IDLE; all strobes, acks and errs 0; mem_addr, mem_write_data, m0/m1_rdata 0; owner=1, so master 0 wins the first tie; timeout counter 0.
- A master request is active when its read or write is 1. If a master asserts both, it is treated as a write (read ignored).
- IDLE: sample requests.
  - Exactly one active: grant it.
  - Both active: grant the master != owner (round-robin).
  - On grant, register owner, mem_addr, mem_write_data, mem_read or mem_write. Go to ACCESS. Strobe is visible the cycle after the request is first sampled (1-cycle grant latency).
- ACCESS: hold all memory outputs stable.
  - Master inputs are ignored; the latched copy is used.
  - On mem_ack=1: deassert strobes next edge, capture mem_read_data into the owner's rdata (reads only; writes leave rdata unchanged), pulse the owner's ack for one cycle, and go to DONE.
- DONE (1 cycle): ack pulse is high and the memory port is idle. Next state is IDLE.
  - This cycle lets the master drop its request, so a stale request is never re-granted.
  - Back-to-back accesses from one master: minimum 3 cycles per transfer with zero-wait memory (IDLE, ACCESS, DONE).
- mem_ack outside ACCESS is ignored.
- The non-owner's ack is never asserted. A request arriving during ACCESS/DONE waits, with no loss.
- Masters must hold address, data and request stable until ack. Changes during ACCESS have no effect.
- Reset asserted mid-transaction: immediate return to reset values. Strobes drop asynchronously and no ack is issued.
- owner and busy are registered outputs.

Optional Feature:
MEM_ARB_TIMEOUT_EN
- Defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle without mem_ack.
  - On reaching TIMEOUT, the arbiter drops the strobes and goes to DONE. The owner's ack and err pulse together, and the owner's rdata is forced to all-ones.
  - mem_ack on the same cycle the count reaches TIMEOUT wins: normal completion, err=0.
- Undefined: no counter is built, m0_err/m1_err are tied 0, and ACCESS waits indefinitely.

Test Plan:
- After reset release, m0_read=1 with m0_addr=0x100; memory acks 2 cycles later with data 0xDEADBEEF -> mem_read=1, mem_addr=0x100 one cycle after the request; m0_ack one cycle after mem_ack with m0_rdata=0xDEADBEEF; m1_ack=0.
- m0 and m1 both write on the same cycle (addresses 0x10 and 0x20) -> m0 served first (owner 0), then m1 with mem_addr=0x20; a third simultaneous pair grants m0 again.
- m1 requests continuously while m0 re-requests every DONE -> grants alternate 0,1,0,1 with no starvation.
- mem_ack pulsed while IDLE -> no ack to either master and no state change; m0_read and m0_write both high -> mem_write=1, mem_read=0.
- reset low during ACCESS -> mem_read/mem_write=0 immediately, no ack; after release, a new m1 request is served normally.
- With MEM_ARB_TIMEOUT_EN and TIMEOUT=4, m0_read with mem_ack never asserted -> strobe drops after 4 ACCESS cycles; m0_ack=m0_err=1 and m0_rdata=0xFFFFFFFF.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between two masters.
// Optional access timeout: define MEM_ARB_TIMEOUT_EN.
module mem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              m0_read,
   input  logic              m0_write,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_ack,
   output logic [DATA_W-1:0] m0_rdata,
   output logic              m0_err,
   input  logic              m1_read,
   input  logic              m1_write,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_ack,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              m1_err,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_write_data,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_read_data,
   output logic              owner,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t state;
   logic   req0;
   logic   req1;
   logic   gnt1;
   logic   gnt_wr;

   assign req0   = m0_read | m0_write;
   assign req1   = m1_read | m1_write;
   // on a tie the master that did not win last time goes next
   assign gnt1   = req1 & (~req0 | ~owner);
   assign gnt_wr = gnt1 ? m1_write : m0_write;

`ifdef MEM_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] cnt;
   logic             tmo;

   assign tmo = (cnt == CNT_W'(TIMEOUT - 1));
`else
   assign m0_err = 1'b0;
   assign m1_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state          <= IDLE;
         owner          <= 1'b1;
         busy           <= 1'b0;
         mem_read       <= 1'b0;
         mem_write      <= 1'b0;
         mem_addr       <= '0;
         mem_write_data <= '0;
         m0_ack         <= 1'b0;
         m1_ack         <= 1'b0;
         m0_rdata       <= '0;
         m1_rdata       <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
         m0_err         <= 1'b0;
         m1_err         <= 1'b0;
         cnt            <= '0;
`endif
      end else begin
         m0_ack <= 1'b0;
         m1_ack <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
         m0_err <= 1'b0;
         m1_err <= 1'b0;
`endif
         unique case (state)
            IDLE: begin
               if (req0 | req1) begin
                  state          <= ACCESS;
                  busy           <= 1'b1;
                  owner          <= gnt1;
                  mem_addr       <= gnt1 ? m1_addr : m0_addr;
                  mem_write_data <= gnt1 ? m1_wdata : m0_wdata;
                  mem_write      <= gnt_wr;
                  mem_read       <= ~gnt_wr;
`ifdef MEM_ARB_TIMEOUT_EN
                  cnt            <= '0;
`endif
               end
            end
            ACCESS: begin
               if (mem_ack) begin
                  state     <= DONE;
                  mem_read  <= 1'b0;
                  mem_write <= 1'b0;
                  if (owner) begin
                     m1_ack <= 1'b1;
                     if (mem_read) m1_rdata <= mem_read_data;
                  end else begin
                     m0_ack <= 1'b1;
                     if (mem_read) m0_rdata <= mem_read_data;
                  end
               end
`ifdef MEM_ARB_TIMEOUT_EN
               else if (tmo) begin
                  state     <= DONE;
                  mem_read  <= 1'b0;
                  mem_write <= 1'b0;
                  if (owner) begin
                     m1_ack   <= 1'b1;
                     m1_err   <= 1'b1;
                     m1_rdata <= '1;
                  end else begin
                     m0_ack   <= 1'b1;
                     m0_err   <= 1'b1;
                     m0_rdata <= '1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
`endif
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
